// File: rtl/sram_arbiter.sv
// Two-port (CPU / loader) arbiter and multi-cycle sequencer for one asynchronous SRAM.
// Every output is registered; each access takes WAIT_CYC strobe cycles plus a one-cycle DONE/ack.
module sram_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy,
  output logic              grant_ld
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              last_ld_q, last_ld_d;
  logic              grant_ld_q, grant_ld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ld_ack_q, ld_ack_d;
  logic              busy_q, busy_d;

  // On a tie the port that did not win last time gets the SRAM.
  logic pick_ld;
  logic sel_we;
  assign pick_ld = ld_req && (!cpu_req || !last_ld_q);
  assign sel_we  = pick_ld ? ld_we : cpu_we;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    last_ld_d   = last_ld_q;
    grant_ld_d  = grant_ld_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    cpu_ack_d   = 1'b0;
    ld_ack_d    = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req || ld_req) begin
          grant_ld_d = pick_ld;
          last_ld_d  = pick_ld;
          wr_d       = sel_we;
          addr_d     = pick_ld ? ld_addr : cpu_addr;
          wdata_d    = pick_ld ? ld_wdata : cpu_wdata;
          cnt_d      = CNT_INIT;
          ce_n_d     = 1'b0;
          oe_n_d     = sel_we;
          we_n_d     = !sel_we;
          busy_d     = 1'b1;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Last strobe cycle: SRAM output has settled for the whole access.
          if (!wr_q) begin
            if (grant_ld_q) ld_rdata_d  = sram_rdata;
            else            cpu_rdata_d = sram_rdata;
          end
          ce_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          cpu_ack_d = !grant_ld_q;
          ld_ack_d  = grant_ld_q;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        busy_d     = 1'b0;
        grant_ld_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      last_ld_q   <= 1'b1;
      grant_ld_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      last_ld_q   <= last_ld_d;
      grant_ld_q  <= grant_ld_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      cpu_ack_q   <= cpu_ack_d;
      ld_ack_q    <= ld_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign ld_rdata   = ld_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign ld_ack     = ld_ack_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign busy       = busy_q;
  assign grant_ld   = grant_ld_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default build plus a WAIT_CYC=1 build sharing one SRAM model.
module tb_sram_arbiter;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, ld_req = 0, ld_we = 0;
  logic [19:0] cpu_addr = '0, ld_addr = '0;
  logic [15:0] cpu_wdata = '0, ld_wdata = '0;
  logic [15:0] cpu_rdata, ld_rdata, sram_wdata, sram_rdata;
  logic [19:0] sram_addr;
  logic        cpu_ack, ld_ack, sram_ce_n, sram_oe_n, sram_we_n, busy, grant_ld;

  logic        c2_req = 0;
  logic [19:0] c2_addr = '0;
  logic [15:0] c2_rdata, s2_wdata, s2_rdata, l2_rdata;
  logic [19:0] s2_addr;
  logic        c2_ack, l2_ack, s2_ce_n, s2_oe_n, s2_we_n, busy2, grant2;

  logic [15:0] mem [0:255];
  logic        pre_we = 0;
  logic [7:0]  pre_a = '0;
  logic [15:0] pre_d = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(W)) dut (
    .Clk(clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .busy(busy), .grant_ld(grant_ld));

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(1)) dut1 (
    .Clk(clk), .Reset(Reset),
    .cpu_req(c2_req), .cpu_we(1'b0), .cpu_addr(c2_addr), .cpu_wdata(16'h0),
    .cpu_rdata(c2_rdata), .cpu_ack(c2_ack),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr(20'h0), .ld_wdata(16'h0),
    .ld_rdata(l2_rdata), .ld_ack(l2_ack),
    .sram_addr(s2_addr), .sram_wdata(s2_wdata), .sram_rdata(s2_rdata),
    .sram_ce_n(s2_ce_n), .sram_oe_n(s2_oe_n), .sram_we_n(s2_we_n),
    .busy(busy2), .grant_ld(grant2));

  // Asynchronous SRAM model: combinational read, write on each edge while strobed.
  assign sram_rdata = mem[sram_addr[7:0]];
  assign s2_rdata   = mem[s2_addr[7:0]];
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (!sram_ce_n && !sram_we_n) mem[sram_addr[7:0]] <= sram_wdata;
  end

  typedef struct {
    bit          is_ld;
    bit          we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pre_we = 1; pre_a = a; pre_d = d;
    @(posedge clk); #1;
    pre_we = 0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    @(posedge clk); #1;
    if (v.is_ld) begin ld_req = 1; ld_we = v.we; ld_addr = v.addr; ld_wdata = v.wdata; end
    else begin cpu_req = 1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; end
    @(negedge clk);
    chk($sformatf("v%0d idle busy", i), {31'b0, busy}, 0);
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k <= W) begin
        chk($sformatf("v%0d strobes c%0d", i, k), {29'b0, sram_ce_n, sram_oe_n, sram_we_n},
            v.we ? 32'd2 : 32'd1);
        chk($sformatf("v%0d addr c%0d", i, k), {12'b0, sram_addr}, {12'b0, v.addr});
        chk($sformatf("v%0d grant c%0d", i, k), {31'b0, grant_ld}, {31'b0, v.is_ld});
        if (v.we) chk($sformatf("v%0d wdata c%0d", i, k), {16'b0, sram_wdata}, {16'b0, v.wdata});
        chk($sformatf("v%0d acks c%0d", i, k), {30'b0, cpu_ack, ld_ack}, 0);
      end else begin
        chk($sformatf("v%0d ack", i), {30'b0, cpu_ack, ld_ack}, v.is_ld ? 32'd1 : 32'd2);
        chk($sformatf("v%0d done strobes", i), {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 7);
        chk($sformatf("v%0d rdata", i), {16'b0, v.is_ld ? ld_rdata : cpu_rdata}, {16'b0, v.exp_rd});
      end
    end
    cpu_req = 0; ld_req = 0;
  endtask

  task automatic tie_run(input string tag);
    logic [1:0] exp;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
    ld_req  = 1; ld_we  = 0; ld_addr  = 20'h00030;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      exp = (c % 4 == 3) ? (((c / 4) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
      chk($sformatf("%s acks c%0d", tag, c), {30'b0, cpu_ack, ld_ack}, {30'b0, exp});
      if (c % 4 == 1)
        chk($sformatf("%s grant c%0d", tag, c), {31'b0, grant_ld}, ((c / 4) % 2 == 1) ? 1 : 0);
      if (exp == 2'b10) chk($sformatf("%s cpu_rdata c%0d", tag, c), {16'b0, cpu_rdata}, 32'h1234);
      if (exp == 2'b01) chk($sformatf("%s ld_rdata c%0d", tag, c), {16'b0, ld_rdata}, 32'hCAFE);
    end
    cpu_req = 0; ld_req = 0;
  endtask

  initial begin
    vecs[0] = '{0, 0, 20'h00030, 16'h0000, 16'hCAFE};
    vecs[1] = '{1, 1, 20'h00020, 16'hBEEF, 16'hCAFE};
    vecs[2] = '{0, 0, 20'h00020, 16'h0000, 16'hBEEF};
    vecs[3] = '{1, 0, 20'h00010, 16'h0000, 16'h1234};
    vecs[4] = '{1, 1, 20'h00040, 16'h5A5A, 16'h1234};
    vecs[5] = '{0, 1, 20'h00020, 16'h0F0F, 16'hBEEF};
    vecs[6] = '{0, 0, 20'h00020, 16'h0000, 16'h0F0F};
    vecs[7] = '{1, 0, 20'h00040, 16'h0000, 16'h5A5A};

    Reset = 1;
    @(posedge clk); #1;
    preload(8'h10, 16'h1234);
    preload(8'h30, 16'hCAFE);
    @(posedge clk); #1;
    Reset = 0;
    @(negedge clk);
    chk("reset strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 7);
    chk("reset acks/busy/grant", {28'b0, cpu_ack, ld_ack, busy, grant_ld}, 0);
    chk("reset rdata", {cpu_rdata, ld_rdata}, 0);
    chk("reset sram bus", {sram_addr[15:0], sram_wdata}, 0);

    tie_run("tie0");

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Request fields change mid-access; the latched address must win.
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
    @(negedge clk);
    @(negedge clk);
    cpu_addr = 20'h00030;
    @(negedge clk);
    chk("stable addr", {12'b0, sram_addr}, 32'h00010);
    @(negedge clk);
    chk("stable ack", {31'b0, cpu_ack}, 1);
    chk("stable rdata", {16'b0, cpu_rdata}, 32'h1234);
    cpu_req = 0;

    // Reset asserted during the second ACCESS cycle aborts the read.
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00030;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    Reset = 1;
    @(negedge clk);
    chk("pre-abort ce_n", {31'b0, sram_ce_n}, 0);
    @(negedge clk);
    chk("abort strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 7);
    chk("abort ack/busy", {29'b0, cpu_ack, ld_ack, busy}, 0);
    chk("abort rdata", {cpu_rdata, ld_rdata}, 0);
    cpu_req = 0;
    @(posedge clk); #1;
    Reset = 0;
    tie_run("tie1");

    // WAIT_CYC=1 build: single strobe cycle, ack two cycles after the request.
    @(posedge clk); #1;
    c2_req = 1; c2_addr = 20'h00030;
    @(negedge clk);
    chk("w1 c0 oe_n", {31'b0, s2_oe_n}, 1);
    @(negedge clk);
    chk("w1 c1 strobes", {29'b0, s2_ce_n, s2_oe_n, s2_we_n}, 1);
    chk("w1 c1 ack", {31'b0, c2_ack}, 0);
    @(negedge clk);
    chk("w1 c2 ack", {31'b0, c2_ack}, 1);
    chk("w1 c2 oe_n", {31'b0, s2_oe_n}, 1);
    chk("w1 rdata", {16'b0, c2_rdata}, 32'hCAFE);
    c2_req = 0;
    @(negedge clk);
    chk("w1 ack pulse", {31'b0, c2_ack}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
